warp_fetch: RTL and testbench

- Instruction fetch stage directly downstream of the GTO warp scheduler.
- Accepts one selected warp (id, PC, mask) and acknowledges it, which drives the scheduler's issue_ack.
- Fetches the 32-bit instruction over a valid/ready imem port and buffers the result in a small FIFO for decode.
- Raises a per-warp fetch_stall vector, OR'd into the scheduler's warp_stall, so each warp has at most one instruction in flight.

---
 rtl/pkg_opengpu.sv | 26 ++
 rtl/fetch_buffer.sv | 87 ++++++++
 rtl/warp_fetch.sv | 122 ++++++++++++
 tb/tb_warp_fetch.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pkg_opengpu.sv
// Shared GPU core types and widths for the scheduler/fetch/decode slice.
// Fetch additions: instruction width, fetch FSM encoding and the fetch buffer entry.
package pkg_opengpu;

  localparam int DATA_WIDTH     = 32;
  localparam int WARP_SIZE      = 32;
  localparam int WARPS_PER_CORE = 8;
  localparam int WARP_ID_WIDTH  = $clog2(WARPS_PER_CORE);
  localparam int INSTR_WIDTH    = 32;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_REQ  = 2'd1,
    FETCH_WAIT = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic                     valid;
    logic [WARP_ID_WIDTH-1:0] warp_id;
    logic [DATA_WIDTH-1:0]    pc;
    logic [WARP_SIZE-1:0]     mask;
    logic [INSTR_WIDTH-1:0]   instr;
    logic                     fault;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Fetched-instruction FIFO with per-entry valid, warp-match invalidate and head auto-skip.
// Head is registered; invalidated heads drain without a decode handshake; the caller guarantees space on push.
module fetch_buffer
  import pkg_opengpu::*;
#(
  parameter int DEPTH     = 2,
  parameter int NUM_WARPS = WARPS_PER_CORE,
  localparam int CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  fetch_entry_t             push_entry_i,
  input  logic                     inv_i,
  input  logic [WARP_ID_WIDTH-1:0] inv_warp_id_i,
  output fetch_entry_t             head_o,
  input  logic                     head_rdy_i,
  output logic [CNT_W-1:0]         count_o,
  output logic [NUM_WARPS-1:0]     warp_busy_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, tail_q;
  logic [CNT_W-1:0] count_q;

  logic         head_hit, head_live, pop;
  fetch_entry_t push_wr;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (int'(p) == DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  // A head being invalidated this cycle is hidden from decode and dropped at once.
  assign head_hit  = inv_i && (mem_q[head_q].warp_id == inv_warp_id_i);
  assign head_live = (count_q != '0) && mem_q[head_q].valid && !head_hit;
  assign pop       = (count_q != '0) && (!head_live || head_rdy_i);
  assign count_o   = count_q;

  always_comb begin
    head_o       = mem_q[head_q];
    head_o.valid = head_live;
    push_wr       = push_entry_i;
    push_wr.valid = push_entry_i.valid && !(inv_i && push_entry_i.warp_id == inv_warp_id_i);
  end

  always_comb begin
    warp_busy_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (mem_q[i].valid && int'(mem_q[i].warp_id) < NUM_WARPS) begin
        warp_busy_o[mem_q[i].warp_id] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (inv_i && mem_q[i].warp_id == inv_warp_id_i) begin
          mem_q[i].valid <= 1'b0;
        end
      end
      if (pop) begin
        mem_q[head_q].valid <= 1'b0;
        head_q              <= ptr_inc(head_q);
      end
      if (push_i) begin
        mem_q[tail_q] <= push_wr;
        tail_q        <= ptr_inc(tail_q);
      end
      case ({push_i, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/warp_fetch.sv
// Single-outstanding instruction fetch between the warp scheduler and decode.
// Ack-to-decode latency 3 cycles minimum; ack is withheld while a fetch is in flight or the buffer has no free slot.
module warp_fetch
  import pkg_opengpu::*;
#(
  parameter int NUM_WARPS  = WARPS_PER_CORE,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     sched_valid,
  input  logic [WARP_ID_WIDTH-1:0] sched_warp_id,
  input  logic [DATA_WIDTH-1:0]    sched_pc,
  input  logic [WARP_SIZE-1:0]     sched_mask,
  output logic                     sched_ack,
  output logic [NUM_WARPS-1:0]     fetch_stall,
  output logic                     imem_req_valid,
  output logic [DATA_WIDTH-1:0]    imem_req_addr,
  input  logic                     imem_req_ready,
  input  logic                     imem_rsp_valid,
  input  logic [INSTR_WIDTH-1:0]   imem_rsp_data,
  input  logic                     imem_rsp_error,
  input  logic                     flush,
  input  logic [WARP_ID_WIDTH-1:0] flush_warp_id,
  output logic                     dec_valid,
  input  logic                     dec_ready,
  output logic [WARP_ID_WIDTH-1:0] dec_warp_id,
  output logic [DATA_WIDTH-1:0]    dec_pc,
  output logic [WARP_SIZE-1:0]     dec_mask,
  output logic [INSTR_WIDTH-1:0]   dec_instr,
  output logic                     dec_fault
);

  localparam int              CNT_W     = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

  fetch_state_t             state_q;
  logic [WARP_ID_WIDTH-1:0] id_q;
  logic [DATA_WIDTH-1:0]    pc_q;
  logic [WARP_SIZE-1:0]     mask_q;
  logic                     drop_q;

  logic                 push;
  fetch_entry_t         push_entry, head;
  logic [CNT_W-1:0]     buf_count;
  logic [NUM_WARPS-1:0] buf_busy;

  // Space is checked against the registered count, so a same-cycle pop does not free a slot.
  assign sched_ack      = (state_q == FETCH_IDLE) && sched_valid && (buf_count < DEPTH_CNT);
  assign imem_req_valid = (state_q == FETCH_REQ);
  assign imem_req_addr  = pc_q;
  assign push           = (state_q == FETCH_WAIT) && imem_rsp_valid && !drop_q;

  always_comb begin
    push_entry.valid   = 1'b1;
    push_entry.warp_id = id_q;
    push_entry.pc      = pc_q;
    push_entry.mask    = mask_q;
    push_entry.instr   = imem_rsp_data;
    push_entry.fault   = imem_rsp_error;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH_IDLE;
      id_q    <= '0;
      pc_q    <= '0;
      mask_q  <= '0;
      drop_q  <= 1'b0;
    end else begin
      case (state_q)
        FETCH_IDLE: if (sched_ack) begin
          id_q    <= sched_warp_id;
          pc_q    <= sched_pc;
          mask_q  <= sched_mask;
          drop_q  <= 1'b0;
          state_q <= FETCH_REQ;
        end
        FETCH_REQ:  if (imem_req_ready) state_q <= FETCH_WAIT;
        FETCH_WAIT: if (imem_rsp_valid) state_q <= FETCH_IDLE;
        default:    state_q <= FETCH_IDLE;
      endcase
      if (flush && state_q != FETCH_IDLE && flush_warp_id == id_q) begin
        drop_q <= 1'b1;
      end
    end
  end

  fetch_buffer #(
    .DEPTH     (FIFO_DEPTH),
    .NUM_WARPS (NUM_WARPS)
  ) u_buf (
    .clk           (clk),
    .rst_n         (rst_n),
    .push_i        (push),
    .push_entry_i  (push_entry),
    .inv_i         (flush),
    .inv_warp_id_i (flush_warp_id),
    .head_o        (head),
    .head_rdy_i    (dec_ready),
    .count_o       (buf_count),
    .warp_busy_o   (buf_busy)
  );

  assign dec_valid   = head.valid;
  assign dec_warp_id = head.warp_id;
  assign dec_pc      = head.pc;
  assign dec_mask    = head.mask;
  assign dec_instr   = head.instr;
  assign dec_fault   = head.valid && head.fault;

  always_comb begin
    fetch_stall = buf_busy;
    if (state_q != FETCH_IDLE && int'(id_q) < NUM_WARPS) begin
      fetch_stall[id_q] = 1'b1;
    end
  end

  rsp_not_in_req: assert property (@(posedge clk) disable iff (!rst_n)
    !(state_q == FETCH_REQ && imem_rsp_valid));

endmodule

// File: tb/tb_warp_fetch.sv
// Directed bench for warp_fetch: fetch timing, memory backpressure, buffer full, flushes, faults, reset.
module tb_warp_fetch;
  import pkg_opengpu::*;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     sched_valid;
  logic [WARP_ID_WIDTH-1:0] sched_warp_id;
  logic [DATA_WIDTH-1:0]    sched_pc;
  logic [WARP_SIZE-1:0]     sched_mask;
  logic                     sched_ack;
  logic [7:0]               fetch_stall;
  logic                     imem_req_valid;
  logic [DATA_WIDTH-1:0]    imem_req_addr;
  logic                     imem_req_ready;
  logic                     imem_rsp_valid;
  logic [INSTR_WIDTH-1:0]   imem_rsp_data;
  logic                     imem_rsp_error;
  logic                     flush;
  logic [WARP_ID_WIDTH-1:0] flush_warp_id;
  logic                     dec_valid;
  logic                     dec_ready;
  logic [WARP_ID_WIDTH-1:0] dec_warp_id;
  logic [DATA_WIDTH-1:0]    dec_pc;
  logic [WARP_SIZE-1:0]     dec_mask;
  logic [INSTR_WIDTH-1:0]   dec_instr;
  logic                     dec_fault;

  int n_checks = 0;
  int n_fail   = 0;

  warp_fetch #(.NUM_WARPS(8), .FIFO_DEPTH(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .sched_valid    (sched_valid),
    .sched_warp_id  (sched_warp_id),
    .sched_pc       (sched_pc),
    .sched_mask     (sched_mask),
    .sched_ack      (sched_ack),
    .fetch_stall    (fetch_stall),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .imem_rsp_error (imem_rsp_error),
    .flush          (flush),
    .flush_warp_id  (flush_warp_id),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .dec_warp_id    (dec_warp_id),
    .dec_pc         (dec_pc),
    .dec_mask       (dec_mask),
    .dec_instr      (dec_instr),
    .dec_fault      (dec_fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Lands 1 time unit after the next rising edge; inputs change here, checks follow a #2 settle.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Zero-wait fetch: ack now, REQ next cycle, response the cycle after; returns when the entry is buffered.
  task automatic do_fetch(input logic [2:0] id, input logic [31:0] pc,
                          input logic [31:0] data, input logic err);
    sched_valid = 1'b1; sched_warp_id = id; sched_pc = pc; sched_mask = 32'hFFFF_0000 | 32'(id);
    imem_req_ready = 1'b1;
    #2 check("fetch_ack", 64'(sched_ack), 64'(1));
    next_cycle();
    sched_valid = 1'b0;
    next_cycle();
    imem_rsp_valid = 1'b1; imem_rsp_data = data; imem_rsp_error = err;
    next_cycle();
    imem_rsp_valid = 1'b0; imem_rsp_error = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; sched_valid = 1'b0; sched_warp_id = '0; sched_pc = '0; sched_mask = '0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0; imem_rsp_error = 1'b0;
    flush = 1'b0; flush_warp_id = '0; dec_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_ack",   64'(sched_ack),      64'(0));
    check("rst_req",   64'(imem_req_valid), 64'(0));
    check("rst_addr",  64'(imem_req_addr),  64'(0));
    check("rst_dec",   64'(dec_valid),      64'(0));
    check("rst_fault", 64'(dec_fault),      64'(0));
    check("rst_stall", 64'(fetch_stall),    64'(0));
    check("rst_instr", 64'(dec_instr),      64'(0));
    rst_n = 1'b1;

    // Basic fetch: warp 3, PC 0x100, zero-wait memory.
    sched_valid = 1'b1; sched_warp_id = 3'd3; sched_pc = 32'h100; sched_mask = 32'hFFFF_FFFF;
    imem_req_ready = 1'b1; dec_ready = 1'b1;
    #2 check("t1_ack_T", 64'(sched_ack), 64'(1));
    check("t1_stall_T", 64'(fetch_stall), 64'(0));
    next_cycle();
    sched_valid = 1'b0;
    #2 check("t1_req_T1", 64'(imem_req_valid), 64'(1));
    check("t1_addr_T1",  64'(imem_req_addr), 64'(32'h100));
    check("t1_stall_T1", 64'(fetch_stall[3]), 64'(1));
    next_cycle();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h13;
    #2 check("t1_req_T2", 64'(imem_req_valid), 64'(0));
    check("t1_stall_T2", 64'(fetch_stall[3]), 64'(1));
    check("t1_dec_T2",   64'(dec_valid), 64'(0));
    next_cycle();
    imem_rsp_valid = 1'b0;
    #2 check("t1_dec_T3", 64'(dec_valid), 64'(1));
    check("t1_id_T3",    64'(dec_warp_id), 64'(3));
    check("t1_instr_T3", 64'(dec_instr), 64'(32'h13));
    check("t1_mask_T3",  64'(dec_mask), 64'(32'hFFFF_FFFF));
    check("t1_stall_T3", 64'(fetch_stall[3]), 64'(1));
    next_cycle();
    #2 check("t1_dec_T4", 64'(dec_valid), 64'(0));
    check("t1_stall_T4", 64'(fetch_stall), 64'(0));

    // Memory backpressure: request held stable, scheduler not acked.
    sched_valid = 1'b1; sched_warp_id = 3'd5; sched_pc = 32'h300; imem_req_ready = 1'b0;
    #2 check("t2_ack", 64'(sched_ack), 64'(1));
    next_cycle();
    sched_warp_id = 3'd6; sched_pc = 32'h400;
    for (int i = 0; i < 5; i++) begin
      #2 check("t2_req_hold", 64'(imem_req_valid), 64'(1));
      check("t2_addr_hold", 64'(imem_req_addr), 64'(32'h300));
      check("t2_no_ack",    64'(sched_ack), 64'(0));
      next_cycle();
    end
    sched_valid = 1'b0; imem_req_ready = 1'b1;
    #2 check("t2_req_last", 64'(imem_req_valid), 64'(1));
    next_cycle();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h55;
    next_cycle();
    imem_rsp_valid = 1'b0;
    #2 check("t2_dec", 64'(dec_valid), 64'(1));
    check("t2_id",    64'(dec_warp_id), 64'(5));
    check("t2_instr", 64'(dec_instr), 64'(32'h55));
    next_cycle();

    // Buffer full: two entries parked, third request refused until a pop.
    dec_ready = 1'b0;
    do_fetch(3'd0, 32'h10, 32'hA0, 1'b0);
    do_fetch(3'd1, 32'h14, 32'hA1, 1'b0);
    sched_valid = 1'b1; sched_warp_id = 3'd2; sched_pc = 32'h20;
    #2 check("t3_full_ack", 64'(sched_ack), 64'(0));
    check("t3_head0", 64'(dec_warp_id), 64'(0));
    next_cycle();
    dec_ready = 1'b1;
    #2 check("t3_pop_cycle_ack", 64'(sched_ack), 64'(0));
    next_cycle();
    dec_ready = 1'b0;
    #2 check("t3_reack", 64'(sched_ack), 64'(1));
    check("t3_head1", 64'(dec_warp_id), 64'(1));

    // Flush warp 2 while its fetch waits for the response.
    next_cycle();
    sched_valid = 1'b0;
    #2 check("t4_addr", 64'(imem_req_addr), 64'(32'h20));
    next_cycle();
    flush = 1'b1; flush_warp_id = 3'd2;
    #2 check("t4_stall_flush", 64'(fetch_stall[2]), 64'(1));
    next_cycle();
    flush = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD;
    #2 check("t4_stall_wait", 64'(fetch_stall[2]), 64'(1));
    next_cycle();
    imem_rsp_valid = 1'b0;
    #2 check("t4_stall_idle", 64'(fetch_stall[2]), 64'(0));
    check("t4_head1", 64'(dec_warp_id), 64'(1));
    dec_ready = 1'b1;
    check("t4_dec1", 64'(dec_valid), 64'(1));
    next_cycle();
    #2 check("t4_no_w2", 64'(dec_valid), 64'(0));
    check("t4_stall_all", 64'(fetch_stall), 64'(0));

    // Flush the head warp: next entry is presented the following cycle.
    dec_ready = 1'b0;
    do_fetch(3'd1, 32'h40, 32'hB1, 1'b0);
    do_fetch(3'd4, 32'h44, 32'hB4, 1'b0);
    #2 check("t5_head1", 64'(dec_warp_id), 64'(1));
    flush = 1'b1; flush_warp_id = 3'd1;
    #1 check("t5_hidden", 64'(dec_valid), 64'(0));
    next_cycle();
    flush = 1'b0;
    #2 check("t5_dec", 64'(dec_valid), 64'(1));
    check("t5_id4",    64'(dec_warp_id), 64'(4));
    check("t5_instr",  64'(dec_instr), 64'(32'hB4));
    check("t5_stall1", 64'(fetch_stall[1]), 64'(0));
    check("t5_stall4", 64'(fetch_stall[4]), 64'(1));
    dec_ready = 1'b1;
    next_cycle();
    #2 check("t5_empty", 64'(dec_valid), 64'(0));

    // Fetch fault propagates with the faulting PC.
    dec_ready = 1'b0;
    do_fetch(3'd6, 32'h200, 32'h0, 1'b1);
    #2 check("t6_dec",   64'(dec_valid), 64'(1));
    check("t6_fault", 64'(dec_fault), 64'(1));
    check("t6_pc",    64'(dec_pc), 64'(32'h200));
    dec_ready = 1'b1;
    next_cycle();
    #2 check("t6_fault_clr", 64'(dec_fault), 64'(0));

    // Reset while a request is pending with a buffered entry.
    dec_ready = 1'b0;
    do_fetch(3'd5, 32'h60, 32'h66, 1'b0);
    sched_valid = 1'b1; sched_warp_id = 3'd7; sched_pc = 32'h300; imem_req_ready = 1'b0;
    next_cycle();
    sched_valid = 1'b0;
    #2 check("t7_req_pre", 64'(imem_req_valid), 64'(1));
    rst_n = 1'b0;
    #1 check("t7_req",   64'(imem_req_valid), 64'(0));
    check("t7_addr",  64'(imem_req_addr), 64'(0));
    check("t7_stall", 64'(fetch_stall), 64'(0));
    check("t7_dec",   64'(dec_valid), 64'(0));
    check("t7_pc",    64'(dec_pc), 64'(0));
    check("t7_ack",   64'(sched_ack), 64'(0));
    next_cycle();
    rst_n = 1'b1; dec_ready = 1'b1;
    do_fetch(3'd2, 32'h80, 32'h77, 1'b0);
    #2 check("t7_post_dec", 64'(dec_valid), 64'(1));
    check("t7_post_id",    64'(dec_warp_id), 64'(2));
    check("t7_post_instr", 64'(dec_instr), 64'(32'h77));
    next_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
